// File: rtl/ssd_req_pkg.sv
// rtl/ssd_req_pkg.sv - state encoding, command field layout and beat-count helper for ssd_req_sequencer
package ssd_req_pkg;

   localparam int ADDR_LSB = 0;
   localparam int LEN_LSB  = 32;
   localparam int LEN_W    = 13;
   localparam int CMD_W    = 45;

   typedef logic [2:0] fsm_state_t;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RD_CMD    = 3'd1;
   localparam logic [2:0] ST_RD_DATA   = 3'd2;
   localparam logic [2:0] ST_WR_CMD    = 3'd3;
   localparam logic [2:0] ST_WR_DATA   = 3'd4;
   localparam logic [2:0] ST_GAP       = 3'd5;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

   // 64-bit beats: round the byte length up to whole beats
   function automatic logic [13:0] beat_count(input logic [LEN_W-1:0] len);
      return (14'(len) + 14'd7) >> 3;
   endfunction

endpackage

// File: rtl/ssd_beat_passthru.sv
// rtl/ssd_beat_passthru.sv - counted valid/ready pass-through, open only while en is high
module ssd_beat_passthru #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [CNT_W-1:0]  load_cnt,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              last,
   output logic              done
);

   logic [CNT_W-1:0] cnt;
   logic             xfer;

   assign m_data  = s_data;
   assign m_valid = en & s_valid;
   assign s_ready = en & m_ready;
   assign xfer    = m_valid & m_ready;
   assign last    = en & (cnt == CNT_W'(1));
   // pulses on the handshake of the final beat
   assign done    = xfer & last;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_cnt;
      end else if (xfer && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/ssd_req_sequencer.sv
// rtl/ssd_req_sequencer.sv - serialises read/write commands and their data beats towards ssd_mem_node
import ssd_req_pkg::*;

module ssd_req_sequencer #(
   parameter int IDLE_GAP   = 8,
   parameter int BEAT_CNT_W = 11
) (
   input  logic        clk156,
   input  logic        rst156,
   input  logic [44:0] s_rdCmd_data,
   input  logic        s_rdCmd_valid,
   output logic        s_rdCmd_ready,
   input  logic [44:0] s_wrCmd_data,
   input  logic        s_wrCmd_valid,
   output logic        s_wrCmd_ready,
   input  logic [63:0] s_wrData_data,
   input  logic        s_wrData_valid,
   output logic        s_wrData_ready,
   output logic [63:0] m_rdData_data,
   output logic        m_rdData_valid,
   input  logic        m_rdData_ready,
   output logic        m_rdData_last,
   output logic [44:0] cmd_dramRdData_data,
   output logic        cmd_dramRdData_valid,
   input  logic        cmd_dramRdData_ready,
   output logic [44:0] cmd_dramWrData_data,
   output logic        cmd_dramWrData_valid,
   input  logic        cmd_dramWrData_ready,
   output logic [63:0] dramWrData_data,
   output logic        dramWrData_valid,
   input  logic        dramWrData_ready,
   input  logic [63:0] dramRdData_data,
   input  logic        dramRdData_valid,
   output logic        dramRdData_ready,
   input  logic        link_initialized_clk156,
   input  logic        ncq_idle_clk156,
   output logic        busy,
   output logic [15:0] zero_len_cnt
);

   fsm_state_t            state;
   logic                  last_grant_wr;
   logic [CMD_W-1:0]      cmd_q;
   logic [15:0]           gap_cnt;
   logic                  can_grant;
   logic                  pick_rd;
   logic                  pick_wr;
   logic                  accept;
   logic [CMD_W-1:0]      grant_cmd;
   logic [LEN_W-1:0]      grant_len;
   logic [BEAT_CNT_W-1:0] grant_beats;
   logic                  rd_done;
   logic                  wr_last;
   logic                  wr_done;

   // new grants need a live link and an idle SSD side; reset masks the handshake
   assign can_grant     = !rst156 && (state == ST_IDLE) && link_initialized_clk156 && ncq_idle_clk156;
   assign pick_rd       = s_rdCmd_valid && (!s_wrCmd_valid || last_grant_wr);
   assign pick_wr       = s_wrCmd_valid && !pick_rd;
   assign s_rdCmd_ready = can_grant && pick_rd;
   assign s_wrCmd_ready = can_grant && pick_wr;
   assign accept        = s_rdCmd_ready || s_wrCmd_ready;
   assign grant_cmd     = pick_rd ? s_rdCmd_data : s_wrCmd_data;
   assign grant_len     = grant_cmd[LEN_LSB +: LEN_W];
   assign grant_beats   = BEAT_CNT_W'(beat_count(grant_len));

   assign cmd_dramRdData_data  = cmd_q;
   assign cmd_dramWrData_data  = cmd_q;
   assign cmd_dramRdData_valid = (state == ST_RD_CMD);
   assign cmd_dramWrData_valid = (state == ST_WR_CMD);
   assign busy                 = (state != ST_IDLE);

   always_ff @(posedge clk156) begin
      if (rst156) begin
         state         <= ST_IDLE;
         last_grant_wr <= 1'b1;
         cmd_q         <= '0;
         gap_cnt       <= '0;
         zero_len_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cmd_q         <= grant_cmd;
                  last_grant_wr <= pick_wr;
                  if (grant_len == '0) begin
                     if (zero_len_cnt != 16'hFFFF) zero_len_cnt <= zero_len_cnt + 16'd1;
                  end else begin
                     state <= pick_rd ? ST_RD_CMD : ST_WR_CMD;
                  end
               end
            end
            ST_RD_CMD:  if (cmd_dramRdData_ready) state <= ST_RD_DATA;
            ST_WR_CMD:  if (cmd_dramWrData_ready) state <= ST_WR_DATA;
            ST_RD_DATA: begin
               if (rd_done) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
               end
            end
            ST_WR_DATA: begin
               if (wr_last && wr_done) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
               end
            end
            ST_GAP: begin
               // let ncq_idle catch up through the node's clock crossing
               if (int'(gap_cnt) + 1 >= IDLE_GAP) state <= ST_WAIT_IDLE;
               else gap_cnt <= gap_cnt + 16'd1;
            end
            ST_WAIT_IDLE: if (ncq_idle_clk156) state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

   ssd_beat_passthru #(.DATA_W(64), .CNT_W(BEAT_CNT_W)) u_rd_pass (
      .clk      (clk156),
      .rst      (rst156),
      .en       (state == ST_RD_DATA),
      .load     (accept && pick_rd && grant_len != '0),
      .load_cnt (grant_beats),
      .s_data   (dramRdData_data),
      .s_valid  (dramRdData_valid),
      .s_ready  (dramRdData_ready),
      .m_data   (m_rdData_data),
      .m_valid  (m_rdData_valid),
      .m_ready  (m_rdData_ready),
      .last     (m_rdData_last),
      .done     (rd_done)
   );

   ssd_beat_passthru #(.DATA_W(64), .CNT_W(BEAT_CNT_W)) u_wr_pass (
      .clk      (clk156),
      .rst      (rst156),
      .en       (state == ST_WR_DATA),
      .load     (accept && pick_wr && grant_len != '0),
      .load_cnt (grant_beats),
      .s_data   (s_wrData_data),
      .s_valid  (s_wrData_valid),
      .s_ready  (s_wrData_ready),
      .m_data   (dramWrData_data),
      .m_valid  (dramWrData_valid),
      .m_ready  (dramWrData_ready),
      .last     (wr_last),
      .done     (wr_done)
   );

endmodule
